// File: rtl/tank_pkg.sv
// Shared codes for tank motion: direction encoding used by the keyboard
// decoder, motion sequencer and renderer, plus the motion state codes.
package tank_pkg;

    localparam logic [2:0] DIR_LEFT  = 3'd0;
    localparam logic [2:0] DIR_RIGHT = 3'd1;
    localparam logic [2:0] DIR_UP    = 3'd2;
    localparam logic [2:0] DIR_DOWN  = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TURN    = 2'd1,
        ST_MOVE    = 2'd2,
        ST_BLOCKED = 2'd3
    } mstate_t;

endpackage

// File: rtl/tick_gen.sv
// Free-running slot counter; tick is high on the last count of each slot.
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/tank_motion_ctrl.sv
// Tank motion sequencer: one turn or one clamped step per slot tick,
// stopping at arena bounds or when the map reports an obstacle.
module tank_motion_ctrl
    import tank_pkg::*;
#(
    parameter int X_W      = 10,
    parameter int Y_W      = 9,
    parameter int STEP_DIV = 500000,
    parameter int STEP     = 2,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 608,
    parameter int Y_MIN    = 0,
    parameter int Y_MAX    = 448,
    parameter int X_INIT   = 304,
    parameter int Y_INIT   = 400
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [2:0]     direct,
    input  logic           moving,
    input  logic           blocked,
    output logic [X_W-1:0] pos_x,
    output logic [Y_W-1:0] pos_y,
    output logic [2:0]     heading,
    output logic [1:0]     state,
    output logic           step_pulse,
    output logic           turn_pulse
);

    localparam int XW1 = X_W + 1;
    localparam int YW1 = Y_W + 1;
    localparam logic [X_W:0]   SX    = XW1'(STEP);
    localparam logic [Y_W:0]   SY    = YW1'(STEP);
    localparam logic [X_W-1:0] XMIN  = X_W'(X_MIN);
    localparam logic [X_W-1:0] XMAX  = X_W'(X_MAX);
    localparam logic [Y_W-1:0] YMIN  = Y_W'(Y_MIN);
    localparam logic [Y_W-1:0] YMAX  = Y_W'(Y_MAX);
    localparam logic [X_W-1:0] XINIT = X_W'(X_INIT);
    localparam logic [Y_W-1:0] YINIT = Y_W'(Y_INIT);

    logic tick;

    tick_gen #(.DIV(STEP_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    mstate_t         st_q, st_d;
    logic [X_W-1:0]  px_d, x_lft, x_rgt;
    logic [Y_W-1:0]  py_d, y_up, y_dn;
    logic [2:0]      hd_d;
    logic            sp_d, tp_d, at_bound;
    logic [X_W:0]    x_add;
    logic [Y_W:0]    y_add;
    logic signed [X_W:0] x_sub;
    logic signed [Y_W:0] y_sub;

    assign state = st_q;

    // One extra bit keeps both directions free of wrap before clamping
    always_comb begin
        x_add = {1'b0, pos_x} + SX;
        y_add = {1'b0, pos_y} + SY;
        x_sub = $signed({1'b0, pos_x}) - $signed(SX);
        y_sub = $signed({1'b0, pos_y}) - $signed(SY);
        x_lft = (x_sub < $signed({1'b0, XMIN})) ? XMIN : x_sub[X_W-1:0];
        x_rgt = (x_add > {1'b0, XMAX}) ? XMAX : x_add[X_W-1:0];
        y_up  = (y_sub < $signed({1'b0, YMIN})) ? YMIN : y_sub[Y_W-1:0];
        y_dn  = (y_add > {1'b0, YMAX}) ? YMAX : y_add[Y_W-1:0];
    end

    always_comb begin
        at_bound = 1'b1;
        case (heading)
            DIR_LEFT:  at_bound = (pos_x <= XMIN);
            DIR_RIGHT: at_bound = (pos_x >= XMAX);
            DIR_UP:    at_bound = (pos_y <= YMIN);
            DIR_DOWN:  at_bound = (pos_y >= YMAX);
            default:   at_bound = 1'b1;
        endcase
    end

    always_comb begin
        px_d = pos_x;
        py_d = pos_y;
        hd_d = heading;
        st_d = st_q;
        sp_d = 1'b0;
        tp_d = 1'b0;
        if (tick) begin
            if (!moving || direct[2]) begin
                st_d = ST_IDLE;
            end else if (direct != heading) begin
                hd_d = direct;
                st_d = ST_TURN;
                tp_d = 1'b1;
            end else if (blocked || at_bound) begin
                st_d = ST_BLOCKED;
            end else begin
                st_d = ST_MOVE;
                sp_d = 1'b1;
                case (heading)
                    DIR_LEFT:  px_d = x_lft;
                    DIR_RIGHT: px_d = x_rgt;
                    DIR_UP:    py_d = y_up;
                    default:   py_d = y_dn;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_x      <= XINIT;
            pos_y      <= YINIT;
            heading    <= DIR_UP;
            st_q       <= ST_IDLE;
            step_pulse <= 1'b0;
            turn_pulse <= 1'b0;
        end else begin
            pos_x      <= px_d;
            pos_y      <= py_d;
            heading    <= hd_d;
            st_q       <= st_d;
            step_pulse <= sp_d;
            turn_pulse <= tp_d;
        end
    end

endmodule
